// File: rtl/pace_pkg.sv
// rtl/pace_pkg.sv - shared state encoding and default constants for the pacing sequencer
package pace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pace_state_t;

  localparam int PRESCALE_120HZ = 41;
  localparam int PACE_CNT_W     = 16;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - wrap counter 0..PRESCALE-1, wrap flags the terminal count while running
module tick_prescaler #(
  parameter int PRESCALE = 41
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  assign wrap = run && (count == CW'(PRESCALE - 1));

  // clear beats run so an abort landing on the terminal count restarts from zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/pace_sequencer.sv
// rtl/pace_sequencer.sv - request-driven tick pacer: start with a count, emit paced ticks, pulse done
module pace_sequencer
  import pace_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_120HZ,
  parameter int CNT_W    = PACE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] ticks,
  input  logic             abort,
  output logic             busy,
  output logic             tick_out,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  pace_state_t      state, state_next;
  logic [CNT_W-1:0] remaining_next;
  logic             tick_next, done_next, busy_next;
  logic             clear, run, wrap;

  assign run = (state == RUN);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .run   (run),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      tick_out  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      tick_out  <= tick_next;
      done      <= done_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    tick_next      = 1'b0;
    done_next      = 1'b0;
    clear          = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          clear          = 1'b1;
          remaining_next = ticks;
          state_next     = (ticks == '0) ? DONE : RUN;
          done_next      = (ticks == '0);
        end
      end
      RUN: begin
        if (abort) begin
          clear          = 1'b1;
          remaining_next = '0;
          state_next     = IDLE;
        end else if (wrap) begin
          tick_next = 1'b1;
          if (remaining != '0) remaining_next = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        // after a run DONE coincides with the final tick; done follows it one cycle later
        state_next = IDLE;
        done_next  = tick_out;
      end
      default: state_next = IDLE;
    endcase
    // busy stays up through the trailing done pulse of a run
    busy_next = (state_next != IDLE) || done_next;
  end

endmodule

// File: tb/tb_pace_sequencer.sv
// tb/tb_pace_sequencer.sv - scoreboard bench for pace_sequencer with PRESCALE=4
module tb_pace_sequencer;

  localparam int P = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ticks = '0;
  logic         abort = 1'b0;
  logic         busy, tick_out, done;
  logic [W-1:0] remaining;

  typedef struct {
    bit is_done;
    int cyc;
    int rem;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;

  pace_sequencer #(.PRESCALE(P), .CNT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ticks     (ticks),
    .abort     (abort),
    .busy      (busy),
    .tick_out  (tick_out),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // every tick_out/done pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (tick_out === 1'b1 || done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {tick_out, done}, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_kind", int'(done), int'(e.is_done));
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_rem", int'(remaining), e.rem);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int base, input int n, input int nticks, input bit with_done);
    for (int k = 1; k <= nticks; k++) sb.push_back('{1'b0, base + k * P, n - k});
    if (with_done) sb.push_back('{1'b1, (n == 0) ? base : base + n * P + 1, 0});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tick"}, int'(tick_out), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rem"}, int'(remaining), 0);
  endtask

  // drive a start; returns with the bench sitting in cycle 0
  task automatic issue(input int n, output int base);
    start = 1'b1;
    ticks = W'(n);
    base  = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic run_full(input int n, input int ign);
    int base, last;
    issue(n, base);
    push_run(base, n, n, 1'b1);
    check("c0_busy", int'(busy), 1);
    check("c0_rem", int'(remaining), n);
    last = (n == 0) ? 0 : n * P + 1;
    for (int c = 0; c < last; c++) begin
      if (c == ign) begin
        start = 1'b1;
        ticks = W'(7);
      end
      step();
      start = 1'b0;
    end
    if (n > 0) check("end_busy_hi", int'(busy), 1);
    step();
    check("end_busy_lo", int'(busy), 0);
    check("end_rem", int'(remaining), 0);
    check("end_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int base;

    repeat (3) step();
    check_quiet("reset");
    reset = 1'b1;
    step();

    run_full(3, -1);
    run_full(0, -1);
    run_full(1, -1);
    run_full(2, 3);

    // abort in cycle 9 of a 5-tick run: two ticks, no done
    issue(5, base);
    push_run(base, 5, 2, 1'b0);
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rem", int'(remaining), 0);
    repeat (10) step();
    check("abort_sb_empty", sb.size(), 0);

    // abort on the final wrap cycle of a 2-tick run
    issue(2, base);
    push_run(base, 2, 1, 1'b0);
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("abort_final");
    repeat (10) step();
    check("abort_final_sb_empty", sb.size(), 0);

    // start and abort together: abort wins
    start = 1'b1;
    abort = 1'b1;
    ticks = W'(3);
    step();
    start = 1'b0;
    abort = 1'b0;
    check_quiet("start_abort");

    // start held high: second request accepted at edge N*P+2
    start = 1'b1;
    ticks = W'(2);
    base  = cyc + 1;
    push_run(base, 2, 2, 1'b1);
    push_run(base + 2 * P + 2, 2, 2, 1'b1);
    step();
    repeat (2 * P + 1) step();
    check("b2b_gap_busy", int'(busy), 1);
    step();
    start = 1'b0;
    check("b2b_second_busy", int'(busy), 1);
    check("b2b_second_rem", int'(remaining), 2);
    repeat (2 * P + 1) step();
    check("b2b_end_busy_hi", int'(busy), 1);
    step();
    check("b2b_end_busy_lo", int'(busy), 0);
    check("b2b_sb_empty", sb.size(), 0);

    // reset in cycle 6 of a 3-tick run
    issue(3, base);
    push_run(base, 3, 1, 1'b0);
    repeat (6) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_quiet("midreset");
    repeat (20) step();
    check_quiet("midreset_after");
    check("midreset_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pace_sequencer.md
# pace_sequencer

Request-driven pacing controller for the draw/animation pipeline. An upstream FSM issues a one-cycle `start` with a tick count. The block runs an internal prescaler, emits one `tick_out` pulse per prescaler period, and returns a one-cycle `done` after the requested number of ticks. It is the initiating side of the enable/done wait handshake: it owns timing and completion instead of free-running on an enable.

## Interface
- `PRESCALE`, default 41: clock cycles per tick (41 = 5000/120, the buffer wait period); legal range ≥ 2.
- `CNT_W`, default 16: width of tick count and `remaining`.
- `clk` input, 1: sole clock; all logic on rising edge.
- `reset` input, 1: synchronous, active-low; 0 on a rising edge resets all state.
- `start` input, 1: request pulse; sampled only in IDLE.
- `ticks` input, CNT_W: tick count; latched when `start` is accepted.
- `abort` input, 1: cancels the current request.
- `busy` output, 1: high whenever the state is not IDLE.
- `tick_out` output, 1: one-cycle pulse at each prescaler wrap while in RUN.
- `done` output, 1: one-cycle completion pulse.
- `remaining` output, CNT_W: ticks still outstanding.

## Operation
- Reset values: state=IDLE, `busy`=0, `tick_out`=0, `done`=0, `remaining`=0, prescaler=0.
- States are IDLE, RUN and DONE.
- **IDLE**
  - `start`=1, `abort`=0, `ticks`≠0: latch `remaining`←`ticks`, clear the prescaler, go to RUN.
  - `start`=1, `ticks`=0: go directly to DONE; no `tick_out`.
  - `start` and `abort` in the same cycle: `abort` wins; stay in IDLE.
- **RUN**
  - The prescaler increments every cycle, counting 0..PRESCALE-1.
  - On the cycle it equals PRESCALE-1: prescaler←0, `tick_out`←1 (registered), `remaining`←`remaining`-1.
  - If that wrap takes `remaining` from 1 to 0, the next state is DONE.
  - `start` in RUN is ignored. The request is not queued and `ticks` is not re-latched.
  - `abort`=1: go to IDLE, prescaler←0, `remaining`←0. No `done` and no `tick_out` that cycle.
  - `abort` coincident with the final wrap: abort wins; no `done`.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
  - `abort` in DONE has no effect; `done` still pulses.
  - A `start` present in the DONE cycle is ignored. It can be accepted on the following cycle in IDLE.
- **Arithmetic**
  - The prescaler is sized to $clog2(PRESCALE).
  - `remaining` never wraps below 0; a decrement happens only when it is ≥1.
- **Mid-operation reset**: `reset`=0 in any state returns to the reset values on that edge. An in-flight `done` or `tick_out` is cancelled.

## Timing
- Define E0 as the edge at which `start` is accepted. "Cycle k" means the cycle after edge Ek.
- `busy` rises in cycle 0 and falls after the DONE cycle.
- The k-th `tick_out` is high in cycle k·PRESCALE; `remaining` shows N−k in that same cycle.
- For N≥1, `done` is high in cycle N·PRESCALE+1, one cycle after the final `tick_out`. `busy` is low in cycle N·PRESCALE+2.
- For N=0, `done` is high in cycle 0 (DONE entered at E0). `busy` is high only in cycle 0.
- The earliest new `start` accepted after `done` is at edge N·PRESCALE+2; the block supports back-to-back requests.

## Structure
- Shared package `pace_pkg`:
  - state enum (IDLE, RUN, DONE);
  - default constants PRESCALE_120HZ=41 and PACE_CNT_W=16.
- Sub-module `tick_prescaler`:
  - ports: `clk`, `reset` (same polarity), `clear`, `run`, output `wrap`;
  - wrap-counts 0..PRESCALE-1;
  - instantiated once; the FSM drives `clear` on accept and abort.
- The top level holds the FSM, the `remaining` counter and output registers only. All outputs are registered.

## Test plan
- Reset with PRESCALE=4: hold `reset`=0 for 3 cycles -> all outputs 0. Release, then `start` with `ticks`=3 -> `tick_out` in cycles 4, 8, 12; `remaining` 2, 1, 0 in those cycles; `done` in cycle 13; `busy` high in cycles 0–13.
- Zero request: `start` with `ticks`=0 -> `done` in cycle 0, no `tick_out`, `busy` high one cycle only.
- Abort: `ticks`=5, PRESCALE=4, `abort` in cycle 9 -> only 2 `tick_out` pulses, no `done`, `busy` low in cycle 10, `remaining`=0. A second `abort` coincident with the final wrap -> no `done`.
- Ignore and back-to-back:
  - `start` with `ticks`=7 during a RUN of 2 ticks -> completion after 2 ticks.
  - `start` held high continuously -> second request accepted at edge N·PRESCALE+2.
- Mid-run reset: `reset`=0 in cycle 6 of a 3-tick run -> next cycle all outputs 0. No `done` afterwards until a new `start`.
